// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell is reused over WIDTH cycles with a registered
// borrow. start/busy/done frame each operation; results hold until the next
// completion or reset.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic             br;
    logic [CW-1:0]    cnt;

    logic x, y, d, br_nx, last, accept;

    // Full-subtractor cell on the current LSBs plus control decode
    always_comb begin
        x      = a_sh[0];
        y      = b_sh[0];
        d      = x ^ y ^ br;
        br_nx  = (~x & y) | (~(x ^ y) & br);
        last   = (cnt == CW'(WIDTH - 1));
        accept = start && (state == IDLE || state == DONE);
        busy   = (state == RUN);
        done   = (state == DONE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; start is only looked at outside RUN
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand/result shift registers, borrow, counter and held outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            r_sh <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            br   <= bin;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            r_sh <= {d, r_sh[WIDTH-1:1]};
            br   <= br_nx;
            cnt  <= cnt + 1'b1;
            if (last) begin
                // br here is the borrow into the MSB stage
                diff <= {d, r_sh[WIDTH-1:1]};
                bout <= br_nx;
                ovf  <= br ^ br_nx;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 directed/random operations with
// handshake timing, hold, back-to-back and reset-abort cases, plus an
// exhaustive WIDTH=4 sweep against an arithmetic reference.
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst;
    logic       s8, bin8, busy8, done8, bout8, ovf8;
    logic [7:0] a8, b8, diff8;
    logic       s4, bin4, busy4, done4, bout4, ovf4;
    logic [3:0] a4, b4, diff4;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [31:0] last8 = '0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(s4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, bout, diff} from integer arithmetic on the operands
    function automatic logic [31:0] ref_sub(input int w, input int ua, input int ub, input int bn);
        int u, sa, sb, r, dv, bo, ov;
        u  = ua - ub - bn;
        bo = (u < 0) ? 1 : 0;
        dv = (u + (1 << w)) % (1 << w);
        sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        r  = sa - sb - bn;
        ov = (r < -(1 << (w - 1)) || r > (1 << (w - 1)) - 1) ? 1 : 0;
        return 32'((ov << (w + 1)) | (bo << w) | dv);
    endfunction

    // Called right after the accepting edge; inputs are scrambled to show they
    // are captured. With hold=1 start stays high into the DONE cycle.
    task automatic finish8(input logic [7:0] ea, input logic [7:0] eb, input logic ebn, input bit hold);
        int          nb;
        bit          seen;
        logic [31:0] e;
        #1;
        s8   = hold;
        a8   = 8'($urandom);
        b8   = 8'($urandom);
        bin8 = 1'($urandom);
        nb   = 0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done8) begin seen = 1; break; end
            if (busy8) begin
                nb++;
                chk("hold_out", 32'({ovf8, bout8, diff8}), 32'(last8[9:0]));
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("busy_cycles", 32'(nb), 32'd8);
        chk("busy_in_done", 32'(busy8), 32'd0);
        e = ref_sub(8, int'(ea), int'(eb), int'(ebn));
        chk("diff8", 32'(diff8), 32'(e[7:0]));
        chk("bout8", 32'(bout8), 32'(e[8]));
        chk("ovf8", 32'(ovf8), 32'(e[9]));
        last8 = e;
        if (!hold) begin
            @(negedge clk);
            chk("done_pulse", 32'(done8), 32'd0);
            chk("idle_busy", 32'(busy8), 32'd0);
        end
    endtask

    task automatic op8(input logic [7:0] ea, input logic [7:0] eb, input logic ebn, input bit hold);
        @(negedge clk);
        a8 = ea; b8 = eb; bin8 = ebn; s8 = 1'b1;
        @(posedge clk);
        finish8(ea, eb, ebn, hold);
    endtask

    task automatic op4(input logic [3:0] ea, input logic [3:0] eb, input logic ebn);
        bit          seen;
        logic [31:0] e;
        @(negedge clk);
        a4 = ea; b4 = eb; bin4 = ebn; s4 = 1'b1;
        @(posedge clk);
        #1;
        s4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done4) begin seen = 1; break; end
        end
        chk("done4_seen", 32'(seen), 32'd1);
        e = ref_sub(4, int'(ea), int'(eb), int'(ebn));
        chk("diff4", 32'(diff4), 32'(e[3:0]));
        chk("bout4", 32'(bout4), 32'(e[4]));
        chk("ovf4", 32'(ovf4), 32'(e[5]));
    endtask

    initial begin
        rst = 1'b1;
        s8 = 0; a8 = 0; b8 = 0; bin8 = 0;
        s4 = 0; a4 = 0; b4 = 0; bin4 = 0;
        repeat (2) @(negedge clk);
        chk("rst_out8", 32'({busy8, done8, ovf8, bout8, diff8}), 32'd0);
        chk("rst_out4", 32'({busy4, done4, ovf4, bout4, diff4}), 32'd0);
        rst = 1'b0;

        // Directed cases
        op8(8'h35, 8'h12, 1'b0, 0);
        op8(8'h00, 8'h01, 1'b0, 0);
        op8(8'h10, 8'h0F, 1'b1, 0);
        op8(8'h80, 8'h01, 1'b0, 0);
        op8(8'h7F, 8'hFF, 1'b0, 0);

        // start held through RUN, then a second op accepted in the DONE cycle
        op8(8'hA5, 8'h3C, 1'b1, 1);
        a8 = 8'h01; b8 = 8'h02; bin8 = 1'b1;
        @(posedge clk);
        finish8(8'h01, 8'h02, 1'b1, 0);

        // Reset during the 4th RUN cycle aborts the operation
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h22; bin8 = 1'b0; s8 = 1'b1;
        @(posedge clk);
        #1 s8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_out", 32'({busy8, done8, ovf8, bout8, diff8}), 32'd0);
        rst = 1'b0;
        last8 = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("abort_nodone", 32'({busy8, done8}), 32'd0);
        end
        op8(8'h55, 8'h22, 1'b0, 0);

        // Random operands
        for (int i = 0; i < 40; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), 0);

        // Exhaustive WIDTH=4 sweep
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++)
                    op4(4'(ia), 4'(ib), 1'(ic));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
